// File: rtl/sys_arr_pkg.sv
// Shared GSAU systolic-array types: psum/write-port geometry, write-back entry and FSM states.
package sys_arr_pkg;

  localparam int unsigned VEGGIEREGS   = 256;
  localparam int unsigned ENTRY_BITS   = $clog2(VEGGIEREGS);
  localparam int unsigned PSUM_BITS    = 512;
  localparam int unsigned WR_PORT_BITS = 128;
  localparam int unsigned NBEATS       = PSUM_BITS / WR_PORT_BITS;

  typedef struct packed {
    logic [ENTRY_BITS-1:0] vdst;
    logic [PSUM_BITS-1:0]  psum;
  } wb_entry_t;

  typedef enum logic [0:0] {
    IDLE,
    WRITE
  } wb_state_t;

endpackage

// File: rtl/gsau_wb_buffer.sv
// In-order register FIFO holding pending write-back rows; head is presented combinationally.
module gsau_wb_buffer
  import sys_arr_pkg::*;
#(
  parameter int unsigned Depth   = 4,
  parameter type         entry_t = wb_entry_t,
  localparam int unsigned CntBits = $clog2(Depth + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  entry_t             push_data_i,
  input  logic               pop_i,
  output entry_t             head_o,
  output logic [CntBits-1:0] count_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int unsigned PtrBits = (Depth > 1) ? $clog2(Depth) : 1;

  entry_t             mem_q [Depth];
  logic [PtrBits-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrBits-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntBits-1:0] count_q, count_d;
  logic               do_push, do_pop;

  // Pointers wrap modulo Depth, which need not be a power of two.
  function automatic logic [PtrBits-1:0] ptr_inc(input logic [PtrBits-1:0] p);
    return (p == PtrBits'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CntBits'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/gsau_wb_unit.sv
// GSAU write-back unit: buffers psum rows and writes them to veggie as NBEATS granted beats.
// Optional GSAU_WB_PERF_EN adds perf_rows / perf_stalls counters.
module gsau_wb_unit #(
  parameter int unsigned VEGGIEREGS   = 256,
  parameter int unsigned PSUM_BITS    = 512,
  parameter int unsigned WR_PORT_BITS = 128,
  parameter int unsigned BUF_DEPTH    = 4,
  localparam int unsigned EntryBits   = $clog2(VEGGIEREGS),
  localparam int unsigned NBeats      = PSUM_BITS / WR_PORT_BITS,
  localparam int unsigned BeatBits    = (NBeats > 1) ? $clog2(NBeats) : 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    wb_valid,
  input  logic [EntryBits-1:0]    wb_wbdst,
  input  logic [PSUM_BITS-1:0]    wb_psum,
  output logic                    wb_output_ready,
  output logic                    rf_wen,
  output logic [EntryBits-1:0]    rf_waddr,
  output logic [BeatBits-1:0]     rf_wbeat,
  output logic [WR_PORT_BITS-1:0] rf_wdata,
  input  logic                    rf_wgrant,
  output logic                    sb_done_valid,
  output logic [EntryBits-1:0]    sb_done_vdst
`ifdef GSAU_WB_PERF_EN
  ,
  output logic [31:0]             perf_rows,
  output logic [31:0]             perf_stalls
`endif
);

  import sys_arr_pkg::*;

  localparam int unsigned CntBits = $clog2(BUF_DEPTH + 1);

  typedef struct packed {
    logic [EntryBits-1:0] vdst;
    logic [PSUM_BITS-1:0] psum;
  } row_t;

  wb_state_t            state_q, state_d;
  logic [BeatBits-1:0]  beat_q, beat_d;
  row_t                 push_row, head;
  logic [CntBits-1:0]   count;
  logic                 full, empty;
  logic                 push, pop, last_beat;
  logic                 done_valid_q;
  logic [EntryBits-1:0] done_vdst_q;

  // Ready depends only on registered occupancy; a same-cycle pop does not free a slot.
  assign wb_output_ready = ~full;
  assign push            = wb_valid & wb_output_ready;
  assign push_row        = '{vdst: wb_wbdst, psum: wb_psum};
  assign last_beat       = (beat_q == BeatBits'(NBeats - 1));
  assign pop             = (state_q == WRITE) & rf_wgrant & last_beat;

  gsau_wb_buffer #(
    .Depth   (BUF_DEPTH),
    .entry_t (row_t)
  ) u_buffer (
    .clk_i       (CLK),
    .rst_i       (RST),
    .push_i      (push),
    .push_data_i (push_row),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      done_valid_q <= 1'b0;
      done_vdst_q  <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      done_valid_q <= pop;
      if (pop) done_vdst_q <= head.vdst;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = WRITE;
          beat_d  = '0;
        end
      end
      WRITE: begin
        if (rf_wgrant) begin
          if (last_beat) begin
            beat_d  = '0;
            // Post-pop occupancy includes a row pushed in the same cycle.
            state_d = ((count > CntBits'(1)) || push) ? WRITE : IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_wbeat = '0;
    rf_wdata = '0;
    if (state_q == WRITE) begin
      rf_wen   = 1'b1;
      rf_waddr = head.vdst;
      rf_wbeat = beat_q;
      rf_wdata = head.psum[int'(beat_q) * WR_PORT_BITS +: WR_PORT_BITS];
    end
  end

  assign sb_done_valid = done_valid_q;
  assign sb_done_vdst  = done_vdst_q;

`ifdef GSAU_WB_PERF_EN
  logic [31:0] perf_rows_q, perf_stalls_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_rows_q   <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (done_valid_q)          perf_rows_q   <= perf_rows_q + 32'd1;
      if (rf_wen && !rf_wgrant)  perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_rows   = perf_rows_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_gsau_wb_unit.sv
// Scoreboard bench for gsau_wb_unit: expected beats/dones queued on acceptance, checked by a monitor.
module tb_gsau_wb_unit;

  localparam int EB    = 8;
  localparam int PB    = 512;
  localparam int WB    = 128;
  localparam int NB    = PB / WB;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          wb_valid = 1'b0;
  logic [EB-1:0] wb_wbdst = '0;
  logic [PB-1:0] wb_psum = '0;
  logic          wb_output_ready;
  logic          rf_wen;
  logic [EB-1:0] rf_waddr;
  logic [1:0]    rf_wbeat;
  logic [WB-1:0] rf_wdata;
  logic          rf_wgrant = 1'b0;
  logic          sb_done_valid;
  logic [EB-1:0] sb_done_vdst;
`ifdef GSAU_WB_PERF_EN
  logic [31:0]   perf_rows, perf_stalls;
`endif

  gsau_wb_unit dut (
    .CLK             (CLK),
    .RST             (RST),
    .wb_valid        (wb_valid),
    .wb_wbdst        (wb_wbdst),
    .wb_psum         (wb_psum),
    .wb_output_ready (wb_output_ready),
    .rf_wen          (rf_wen),
    .rf_waddr        (rf_waddr),
    .rf_wbeat        (rf_wbeat),
    .rf_wdata        (rf_wdata),
    .rf_wgrant       (rf_wgrant),
    .sb_done_valid   (sb_done_valid),
    .sb_done_vdst    (sb_done_vdst)
`ifdef GSAU_WB_PERF_EN
    ,
    .perf_rows       (perf_rows),
    .perf_stalls     (perf_stalls)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [EB-1:0] vdst;
    logic [1:0]    beat;
    logic [WB-1:0] data;
    int            cyc;
  } beat_t;
  typedef struct {
    logic [EB-1:0] vdst;
    int            cyc;
  } done_t;

  beat_t exp_beats[$];
  done_t exp_dones[$];
  int    n_cmp = 0, n_fail = 0;
  int    cyc = 0, model_cnt = 0, rows_seen = 0, stalls_seen = 0;
  bit    done_due = 0, prev_stall = 0, lat_chk = 0;
  logic [EB-1:0] p_addr;
  logic [1:0]    p_beat;
  logic [WB-1:0] p_data;
  int    gmode = 0;  // 0: grant low, 1: high, 2: toggle, 3: random
  beat_t mb;
  done_t md;

  task automatic chk(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Monitor / scoreboard: everything sampled at the falling edge.
  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      exp_beats.delete();
      exp_dones.delete();
      model_cnt   = 0;
      done_due    = 0;
      prev_stall  = 0;
      rows_seen   = 0;
      stalls_seen = 0;
    end else begin
      chk("ready", wb_output_ready, model_cnt < DEPTH);
      chk("done_timing", sb_done_valid, done_due);
      if (sb_done_valid) begin
        if (exp_dones.size() == 0) fail("done_unexpected");
        else begin
          md = exp_dones.pop_front();
          chk("done_vdst", sb_done_vdst, md.vdst);
          if (md.cyc >= 0) chk("done_cycle", cyc, md.cyc);
        end
        rows_seen++;
      end
      done_due = 0;
      if (prev_stall) begin
        chk("hold_wen", rf_wen, 1'b1);
        chk("hold_addr", rf_waddr, p_addr);
        chk("hold_beat", rf_wbeat, p_beat);
        chk("hold_data", rf_wdata, p_data);
      end
      if (rf_wen && exp_beats.size() == 0) fail("wen_unexpected");
      else if (rf_wen && rf_wgrant) begin
        mb = exp_beats.pop_front();
        chk("beat_addr", rf_waddr, mb.vdst);
        chk("beat_idx", rf_wbeat, mb.beat);
        chk("beat_data", rf_wdata, mb.data);
        if (mb.cyc >= 0) chk("beat_cycle", cyc, mb.cyc);
        if (mb.beat == 2'(NB - 1)) begin
          model_cnt--;
          done_due = 1;
        end
      end
      prev_stall = rf_wen && !rf_wgrant;
      if (prev_stall) stalls_seen++;
      p_addr = rf_waddr;
      p_beat = rf_wbeat;
      p_data = rf_wdata;
      if (wb_valid && wb_output_ready) begin
        for (int k = 0; k < NB; k++) begin
          mb.vdst = wb_wbdst;
          mb.beat = 2'(k);
          mb.data = wb_psum[k*WB +: WB];
          mb.cyc  = lat_chk ? cyc + 2 + k : -1;
          exp_beats.push_back(mb);
        end
        md.vdst = wb_wbdst;
        md.cyc  = lat_chk ? cyc + 2 + NB : -1;
        exp_dones.push_back(md);
        model_cnt++;
      end
    end
  end

  // Grant driver.
  initial begin
    bit tog = 0;
    forever begin
      @(posedge CLK);
      #1;
      case (gmode)
        0: rf_wgrant = 1'b0;
        1: rf_wgrant = 1'b1;
        2: begin tog = ~tog; rf_wgrant = tog; end
        default: rf_wgrant = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [PB-1:0] rand_psum();
    logic [PB-1:0] p;
    for (int i = 0; i < PB / 32; i++) p[i*32 +: 32] = $urandom();
    return p;
  endfunction

  task automatic send(input logic [EB-1:0] v, input logic [PB-1:0] p);
    bit ok = 0;
    int n = 0;
    wb_valid = 1'b1;
    wb_wbdst = v;
    wb_psum  = p;
    while (!ok && n < 2000) begin
      @(negedge CLK);
      ok = wb_output_ready;
      tick();
      n++;
    end
    if (!ok) fail("send_timeout");
    wb_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_beats.size() != 0 || exp_dones.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) fail("drain_timeout");
    tick();
    tick();
  endtask

  initial begin
    logic [PB-1:0] p;
    int n;
    bit seen;
    repeat (3) tick();
    RST = 1'b0;
    // Reset values and idle behaviour.
    @(negedge CLK);
    chk("rst_waddr", rf_waddr, '0);
    chk("rst_wbeat", rf_wbeat, '0);
    chk("rst_wdata", rf_wdata, '0);
    chk("rst_done_vdst", sb_done_vdst, '0);
    chk("rst_wen", rf_wen, 1'b0);
    repeat (10) tick();

    // Single row, continuous grant, exact latency.
    gmode = 1;
    tick();
    for (int k = 0; k < NB; k++) p[k*WB +: WB] = WB'(k);
    lat_chk = 1;
    send(8'h2A, p);
    lat_chk = 0;
    drain();

    // Fill with no grant, then a rejected fifth row.
    gmode = 0;
    tick();
    for (int v = 1; v <= 4; v++) send(EB'(v), rand_psum());
    wb_valid = 1'b1;
    wb_wbdst = 8'd5;
    wb_psum  = rand_psum();
    repeat (6) tick();
    @(negedge CLK);
    chk("full_ready", wb_output_ready, 1'b0);
    chk("full_head_addr", rf_waddr, 8'd1);
    chk("full_head_beat", rf_wbeat, 2'd0);

    // Toggling grant; the held fifth row lands once a slot frees.
    gmode = 2;
    send(8'd5, wb_psum);
    send(8'd6, rand_psum());
    drain();

    // Random traffic with repeated destinations.
    gmode = 3;
    for (int r = 0; r < 40; r++) begin
      send(($urandom_range(0, 3) == 0) ? EB'($urandom_range(0, 2)) : EB'($urandom()),
           rand_psum());
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();

    // Reset in the middle of a row.
    gmode = 1;
    send(8'd7, rand_psum());
    seen = 0;
    n = 0;
    while (!seen && n < 100) begin
      @(negedge CLK);
      seen = rf_wen && rf_wgrant && (rf_wbeat == 2'd1) && (rf_waddr == 8'd7);
      tick();
      n++;
    end
    if (!seen) fail("midrow_beat1_timeout");
    RST   = 1'b1;
    gmode = 0;
    repeat (2) tick();
    RST = 1'b0;
    gmode = 1;
    repeat (8) tick();
    send(8'h33, rand_psum());
    drain();

`ifdef GSAU_WB_PERF_EN
    @(negedge CLK);
    chk("perf_rows", perf_rows, rows_seen);
    chk("perf_stalls", perf_stalls, stalls_seen);
`endif
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
